button_gesture_decoder: RTL and testbench
=========================================

// Module: button_gesture_decoder
// PURPOSE
//  Consumes the clean level from the debouncer.
//  Turns button activity into single-cycle gesture events for the rgb_sequencer control logic:
//  press/release edges, short press, double press, long press, and auto-repeat while held.
//  Sits directly after the debouncer; all outputs are registered.
// PARAMETERS
//  LONG_TICKS    default 1000  cycles held (after press_pulse) before long_press fires; >=2
//  REPEAT_TICKS  default 250   cycles between repeat_pulse while in long-hold; >=2
//  DOUBLE_TICKS  default 300   max release gap (cycles) for a second press to count as double; >=2
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  asynchronous, active-low reset (0 = reset)
//  debounced_in   in   1  clean button level from debouncer, 1 = pressed
//  press_pulse    out  1  1-cycle pulse on every rising edge of debounced_in
//  release_pulse  out  1  1-cycle pulse on every falling edge of debounced_in
//  short_press    out  1  1-cycle pulse: single press released before LONG, no 2nd press in window
//  double_press   out  1  1-cycle pulse: 2nd rising edge within DOUBLE_TICKS of a short release
//  long_press     out  1  1-cycle pulse when hold reaches LONG_TICKS
//  repeat_pulse   out  1  1-cycle pulse every REPEAT_TICKS cycles after long_press, while held
//  held           out  1  level: 1 while FSM in S_PRESSED, S_LONG or S_SECOND
// BEHAVIOUR
//  - rst=0: state<=S_IDLE, counter<=0, in_q<=0, all outputs 0, immediately (async).
//  - in_q registers debounced_in each cycle.
//    rise = debounced_in & ~in_q; fall = ~debounced_in & in_q.
//    Outputs are registered: visible the cycle after the clock edge that sampled the event.
//  - press_pulse/release_pulse fire on every rise/fall regardless of state.
//  - Counter: $clog2(max(LONG,REPEAT,DOUBLE_TICKS))+1 bits.
//    Cleared on every state entry; increments once per cycle in timed states; never wraps.
//  - FSM states and transitions:
//    S_IDLE:   rise -> S_PRESSED.
//    S_PRESSED: fall -> S_WAIT_SECOND (short path).
//              Else if counter==LONG_TICKS-1 -> S_LONG, long_press.
//              Else counter++.
//    S_LONG:   fall -> S_IDLE, no short/double event.
//              Else if counter==REPEAT_TICKS-1 -> repeat_pulse, counter<=0.
//              Else counter++.
//    S_WAIT_SECOND: rise -> S_SECOND, double_press.
//              Else if counter==DOUBLE_TICKS-1 -> S_IDLE, short_press.
//              Else counter++.
//    S_SECOND: fall -> S_IDLE. No long/repeat detection in this state.
//  - Timing: press_pulse visible at cycle N -> long_press at N+LONG_TICKS;
//    first repeat_pulse at N+LONG_TICKS+REPEAT_TICKS, then every REPEAT_TICKS.
//  - Simultaneous events:
//    fall on the same edge as LONG expiry -> fall wins (short path, no long_press).
//    rise on the same edge as DOUBLE expiry -> rise wins (double_press, no short_press).
//  - At most one of short/double/long/repeat asserted in any cycle.
//  - Reset mid-gesture: no pending event is emitted.
//    Button held through reset release yields press_pulse on the first sampled edge (in_q resets 0).
//  - Unreachable state encodings -> S_IDLE.
// TESTING (LONG_TICKS=8, REPEAT_TICKS=4, DOUBLE_TICKS=6)
//  1. Hold in=1 for 3 cycles, release, idle 10
//     -> press_pulse, release_pulse; short_press exactly 6 cycles after release_pulse; no others.
//  2. Press 3 cycles, release 2, press again
//     -> double_press coincident with 2nd press_pulse; short_press never fires.
//  3. Hold 20 cycles
//     -> long_press at N+8; repeat_pulse at N+12, N+16, N+20.
//     On release: release_pulse only, held drops.
//  4. Release timed to the edge where counter==7 in S_PRESSED
//     -> no long_press; short_press follows 6 cycles later.
//     2nd rise timed to DOUBLE expiry -> double_press, no short_press.
//  5. Assert rst=0 mid S_LONG with in=1, release rst with in still 1
//     -> outputs 0 during reset; press_pulse next cycle; no repeat_pulse before N+12.
//  6. Random in toggling 2000 cycles vs reference model
//     -> pulses exactly 1 cycle wide; event exclusivity holds.

Source files
------------

// File: rtl/button_gesture_decoder_if.sv
// button_gesture_decoder_if: button level in, registered gesture events out
interface button_gesture_decoder_if;
    logic debounced_in;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_pulse;
    logic held;
    modport master (
        output debounced_in,
        input  press_pulse, release_pulse, short_press, double_press,
               long_press, repeat_pulse, held
    );
    modport slave (
        input  debounced_in,
        output press_pulse, release_pulse, short_press, double_press,
               long_press, repeat_pulse, held
    );
endinterface

// File: rtl/button_gesture_decoder.sv
// button_gesture_decoder: turns a debounced button level into single-cycle gesture events
module button_gesture_decoder #(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 250,
    parameter int DOUBLE_TICKS = 300
) (
    input  logic                      clk,
    input  logic                      rst,
    button_gesture_decoder_if.slave   bus
);
    localparam int MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int MAX_T  = (MAX_LR > DOUBLE_TICKS) ? MAX_LR : DOUBLE_TICKS;
    localparam int CW     = $clog2(MAX_T) + 1;
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRESSED, S_LONG, S_WAIT_SECOND, S_SECOND
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            in_q, rise, fall;
    logic            short_n, double_n, long_n, repeat_n;

    assign rise = bus.debounced_in & ~in_q;
    assign fall = ~bus.debounced_in & in_q;
    assign bus.held = state inside {S_PRESSED, S_LONG, S_SECOND};

    // next state, counter and event decode; edges win over timer expiry
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        short_n  = 1'b0;
        double_n = 1'b0;
        long_n   = 1'b0;
        repeat_n = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rise) state_n = S_PRESSED;
            end
            S_PRESSED: begin
                if (fall) state_n = S_WAIT_SECOND;
                else if (cnt == LONG_LAST) begin
                    state_n = S_LONG;
                    long_n  = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) state_n = S_IDLE;
                else if (cnt == REPEAT_LAST) begin
                    repeat_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            S_WAIT_SECOND: begin
                if (rise) begin
                    state_n  = S_SECOND;
                    double_n = 1'b1;
                end else if (cnt == DOUBLE_LAST) begin
                    state_n = S_IDLE;
                    short_n = 1'b1;
                end
            end
            S_SECOND: begin
                cnt_n = '0;
                if (fall) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        if (state_n != state) cnt_n = '0;
    end

    // state, edge history and registered event outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= S_IDLE;
            cnt                <= '0;
            in_q               <= 1'b0;
            bus.press_pulse    <= 1'b0;
            bus.release_pulse  <= 1'b0;
            bus.short_press    <= 1'b0;
            bus.double_press   <= 1'b0;
            bus.long_press     <= 1'b0;
            bus.repeat_pulse   <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            in_q               <= bus.debounced_in;
            bus.press_pulse    <= rise;
            bus.release_pulse  <= fall;
            bus.short_press    <= short_n;
            bus.double_press   <= double_n;
            bus.long_press     <= long_n;
            bus.repeat_pulse   <= repeat_n;
        end
    end
endmodule

// File: tb/tb_button_gesture_decoder.sv
// tb_button_gesture_decoder: directed gestures plus random toggling against a timestamp-based gesture model
module tb_button_gesture_decoder;
    localparam int L = 8;
    localparam int R = 4;
    localparam int D = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    button_gesture_decoder_if bus();
    button_gesture_decoder #(.LONG_TICKS(L), .REPEAT_TICKS(R), .DOUBLE_TICKS(D)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef enum {M_IDLE, M_FIRST, M_GAP, M_SECOND} mode_t;
    mode_t      mode = M_IDLE;
    int         k = 0, press_t = 0, rel_t = 0;
    bit         prev = 1'b0;
    logic [6:0] exp_o = '0;
    int         n_checks = 0, n_fail = 0;
    int         n_short = 0, n_double = 0, n_long = 0, n_rep = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.press_pulse, bus.release_pulse, bus.short_press, bus.double_press,
                bus.long_press, bus.repeat_pulse, bus.held};
    endfunction

    // gesture model: events derived from press/release timestamps measured in clock edges
    task automatic model(input bit v);
        bit rise, fall, s, d, lp, rp;
        int hold;
        rise = v & ~prev;
        fall = ~v & prev;
        s = 0; d = 0; lp = 0; rp = 0;
        k++;
        hold = k - press_t;
        case (mode)
            M_IDLE: if (rise) begin mode = M_FIRST; press_t = k; end
            M_FIRST: begin
                if (fall) begin
                    if (hold > L) mode = M_IDLE;
                    else begin mode = M_GAP; rel_t = k; end
                end else if (hold == L) lp = 1;
                else if (hold > L && (hold - L) % R == 0) rp = 1;
            end
            M_GAP: begin
                if (rise) begin d = 1; mode = M_SECOND; end
                else if (k - rel_t == D) begin s = 1; mode = M_IDLE; end
            end
            M_SECOND: if (fall) mode = M_IDLE;
        endcase
        prev = v;
        exp_o = {rise, fall, s, d, lp, rp, (mode == M_FIRST || mode == M_SECOND)};
    endtask

    task automatic step(input bit v);
        logic [6:0] o;
        bus.debounced_in = v;
        @(posedge clk);
        model(v);
        @(negedge clk);
        o = obs();
        check("outs", {25'b0, o}, {25'b0, exp_o});
        check("excl", 32'($countones(o[4:1]) <= 1), 1);
        n_short  += int'(o[4]);
        n_double += int'(o[3]);
        n_long   += int'(o[2]);
        n_rep    += int'(o[1]);
    endtask

    task automatic do_reset(input bit v);
        bus.debounced_in = v;
        rst = 1'b0;
        #1 check("rst_async", {25'b0, obs()}, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", {25'b0, obs()}, 0);
        mode = M_IDLE;
        prev = 1'b0;
        rst = 1'b1;
    endtask

    task automatic clear_counts();
        n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
    endtask

    initial begin
        bit v;
        int cyc, len;
        bus.debounced_in = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        clear_counts();
        repeat (3) step(1);
        repeat (11) step(0);
        check("t1_short", n_short, 1);
        check("t1_other", n_double + n_long + n_rep, 0);

        clear_counts();
        repeat (3) step(1);
        repeat (2) step(0);
        repeat (3) step(1);
        repeat (10) step(0);
        check("t2_double", n_double, 1);
        check("t2_short", n_short, 0);

        clear_counts();
        repeat (21) step(1);
        repeat (5) step(0);
        check("t3_long", n_long, 1);
        check("t3_repeat", n_rep, 3);
        check("t3_short", n_short + n_double, 0);

        clear_counts();
        repeat (8) step(1);
        repeat (10) step(0);
        check("t4a_long", n_long, 0);
        check("t4a_short", n_short, 1);

        clear_counts();
        repeat (8) step(1);
        repeat (6) step(0);
        repeat (3) step(1);
        repeat (10) step(0);
        check("t4b_double", n_double, 1);
        check("t4b_short", n_short + n_long, 0);

        repeat (12) step(1);
        clear_counts();
        do_reset(1'b1);
        repeat (14) step(1);
        repeat (3) step(0);
        check("t5_long", n_long, 1);
        check("t5_repeat", n_rep, 1);

        v = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            v = ~v;
            len = $urandom_range(1, 14);
            repeat (len) step(v);
            cyc += len;
        end
        repeat (12) step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
